// File: rtl/step_sequencer_ctrl.sv
// step_sequencer_ctrl: walks a one-hot grant across up to seven channels,
// dwelling a programmable number of cycles on each and skipping masked
// channels. It signals each completed sweep with a one-cycle wrap pulse.
module step_sequencer_ctrl #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned NCH     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               step_req,
  input  logic               dir,
  input  logic [NCH-1:0]     mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NCH-1:0]     grant,
  output logic [2:0]         index,
  output logic               valid,
  output logic               wrap
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NCH-1:0]     grant_q, grant_d;
  logic [2:0]         index_q, index_d;
  logic               valid_q, valid_d;
  logic               wrap_q,  wrap_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;

  // Neighbouring channel index in the search direction, wrapping modulo 7.
  function automatic logic [2:0] step_idx(input logic [2:0] p, input logic d);
    if (!d) step_idx = (p == 3'd6) ? 3'd0 : p + 3'd1;
    else    step_idx = (p == 3'd0) ? 3'd6 : p - 3'd1;
  endfunction

  // First enabled channel probing from start inclusive. An advance calls
  // this with the neighbour of the current index, so the seventh probe
  // lands back on the current channel and covers the single-channel case.
  function automatic logic [2:0] find_ch(input logic [2:0] start, input logic d,
                                         input logic [NCH-1:0] m);
    logic [2:0] p;
    logic       found;
    find_ch = start;
    found   = 1'b0;
    p       = start;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && m[p]) begin
        find_ch = p;
        found   = 1'b1;
      end
      p = step_idx(p, d);
    end
  endfunction

  logic [2:0] entry_tgt;
  logic [2:0] adv_tgt;
  logic       adv_wrap;

  // Candidate targets for entry and advance, and the sweep-completion test.
  always_comb begin
    entry_tgt = find_ch(index_q, dir, mask);
    adv_tgt   = find_ch(step_idx(index_q, dir), dir, mask);
    adv_wrap  = dir ? (adv_tgt >= index_q) : (adv_tgt <= index_q);
  end

  // Next-state and output decode, highest-priority condition first.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    index_d = index_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if ((en || step_req) && (mask != '0)) begin
          state_d = ACTIVE;
          index_d = entry_tgt;
          grant_d = {{(NCH-1){1'b0}}, 1'b1} << entry_tgt;
          valid_d = 1'b1;
          cnt_d   = dwell;
        end
      end
      ACTIVE: begin
        if (mask == '0) begin
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
        end else if (!mask[index_q] || step_req || (en && (cnt_q == '0))) begin
          index_d = adv_tgt;
          grant_d = {{(NCH-1){1'b0}}, 1'b1} << adv_tgt;
          wrap_d  = adv_wrap;
          cnt_d   = dwell;
        end else if (en) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      index_q <= index_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign index = index_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Directed testbench for step_sequencer_ctrl with hand-computed expectations.
module tb_step_sequencer_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       step_req;
  logic       dir;
  logic [6:0] mask;
  logic [7:0] dwell;
  logic [6:0] grant;
  logic [2:0] index;
  logic       valid;
  logic       wrap;

  int checks;
  int errors;

  step_sequencer_ctrl #(.DWELL_W(8), .NCH(7)) dut (
    .clk(clk), .rst(rst), .en(en), .step_req(step_req), .dir(dir),
    .mask(mask), .dwell(dwell), .grant(grant), .index(index),
    .valid(valid), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; step_req = 1'b0; dir = 1'b0; mask = '0; dwell = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, index, valid, wrap} !== 12'h000) begin
      $display("FAIL reset_outputs grant=%h index=%0d valid=%b wrap=%b required all zero",
               grant, index, valid, wrap);
      errors++;
    end
    mask = 7'h7F; dwell = 8'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || grant !== 7'h00) begin
        $display("FAIL idle_hold cycle=%0d valid=%b grant=%h required 0/00", i, valid, grant);
        errors++;
      end
    end
  endtask

  task automatic test_ascending();
    logic [6:0] eg;
    logic       ew;
    do_reset();
    mask = 7'h7F; dwell = 8'd2; dir = 1'b0; en = 1'b1;
    for (int c = 0; c < 45; c++) begin
      tick();
      eg = 7'h01 << ((c / 3) % 7);
      ew = (c > 0) && (c % 21 == 0);
      checks++;
      if (grant !== eg || index !== 3'((c / 3) % 7) || valid !== 1'b1 || wrap !== ew) begin
        $display("FAIL ascending c=%0d grant=%h index=%0d valid=%b wrap=%b required grant=%h index=%0d valid=1 wrap=%b",
                 c, grant, index, valid, wrap, eg, (c / 3) % 7, ew);
        errors++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_descending_sparse();
    logic [2:0] seq [9];
    seq = '{3'd0, 3'd5, 3'd2, 3'd0, 3'd5, 3'd2, 3'd0, 3'd5, 3'd2};
    do_reset();
    mask = 7'b0100101; dwell = 8'd0; dir = 1'b1; en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      checks++;
      if (index !== seq[c] || grant !== (7'h01 << seq[c]) ||
          wrap !== ((c > 0) && (seq[c] == 3'd5))) begin
        $display("FAIL descending c=%0d index=%0d grant=%h wrap=%b required index=%0d wrap=%b",
                 c, index, grant, wrap, seq[c], (c > 0) && (seq[c] == 3'd5));
        errors++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_single_step();
    logic [6:0] exp_g [10];
    do_reset();
    mask = 7'h7F; dwell = 8'd3; dir = 1'b0; en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      for (int h = 0; h < 3; h++) begin
        checks++;
        if (grant !== (7'h01 << p)) begin
          $display("FAIL single_step pulse=%0d hold=%0d grant=%h required %h", p, h, grant, 7'h01 << p);
          errors++;
        end
        tick();
      end
    end
    // grant 0x04 with counter at 3: run 2 cycles, pause 4, run again.
    exp_g = '{7'h04, 7'h04, 7'h04, 7'h04, 7'h04, 7'h04, 7'h04, 7'h08, 7'h08, 7'h08};
    for (int c = 0; c < 10; c++) begin
      en = (c < 2 || c >= 6);
      tick();
      checks++;
      if (grant !== exp_g[c]) begin
        $display("FAIL counter_hold c=%0d grant=%h required %h", c, grant, exp_g[c]);
        errors++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_mask_edges();
    do_reset();
    mask = 7'h7F; dwell = 8'd5; dir = 1'b0; en = 1'b1;
    tick();
    tick();
    en = 1'b0; mask = 7'h7E;
    tick();
    checks++;
    if (grant !== 7'h02 || index !== 3'd1 || wrap !== 1'b0 || valid !== 1'b1) begin
      $display("FAIL masked_current grant=%h index=%0d wrap=%b required 02/1/0", grant, index, wrap);
      errors++;
    end
    en = 1'b1;
    tick();
    mask = 7'h00;
    tick();
    checks++;
    if (valid !== 1'b0 || grant !== 7'h00 || index !== 3'd1 || wrap !== 1'b0) begin
      $display("FAIL mask_zero valid=%b grant=%h index=%0d wrap=%b required 0/00/1/0",
               valid, grant, index, wrap);
      errors++;
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      $display("FAIL mask_zero_stay valid=%b required 0", valid);
      errors++;
    end
    mask = 7'b0000110;
    tick();
    checks++;
    if (valid !== 1'b1 || grant !== 7'h02 || index !== 3'd1 || wrap !== 1'b0) begin
      $display("FAIL mask_restore valid=%b grant=%h index=%0d wrap=%b required 1/02/1/0",
               valid, grant, index, wrap);
      errors++;
    end
    en = 1'b0;
  endtask

  task automatic test_single_channel();
    do_reset();
    mask = 7'b0001000; dwell = 8'd1; dir = 1'b0; en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (grant !== 7'h08 || index !== 3'd3 || wrap !== ((c >= 2) && (c % 2 == 0))) begin
        $display("FAIL single_channel c=%0d grant=%h index=%0d wrap=%b required 08/3/%b",
                 c, grant, index, wrap, (c >= 2) && (c % 2 == 0));
        errors++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    mask = 7'h7F; dwell = 8'd1; dir = 1'b0; en = 1'b1;
    tick();
    tick();
    checks++;
    if (grant !== 7'h01) begin
      $display("FAIL b2b_setup grant=%h required 01", grant);
      errors++;
    end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    checks++;
    if (grant !== 7'h02) begin
      $display("FAIL b2b_single_advance grant=%h required 02", grant);
      errors++;
    end
    tick();
    checks++;
    if (grant !== 7'h02) begin
      $display("FAIL b2b_reload grant=%h required 02", grant);
      errors++;
    end
    tick();
    checks++;
    if (grant !== 7'h04) begin
      $display("FAIL b2b_next grant=%h required 04", grant);
      errors++;
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mask = 7'h7F; dwell = 8'd4; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (grant !== 7'h02 || index !== 3'd1) begin
      $display("FAIL reset_mid_setup grant=%h index=%0d required 02/1", grant, index);
      errors++;
    end
    rst = 1'b1; step_req = 1'b1;
    tick();
    rst = 1'b0; step_req = 1'b0; en = 1'b0;
    checks++;
    if ({grant, index, valid, wrap} !== 12'h000) begin
      $display("FAIL reset_mid grant=%h index=%0d valid=%b wrap=%b required all zero",
               grant, index, valid, wrap);
      errors++;
    end
    tick();
    checks++;
    if (valid !== 1'b0 || wrap !== 1'b0) begin
      $display("FAIL reset_mid_idle valid=%b wrap=%b required 0/0", valid, wrap);
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; step_req = 1'b0; dir = 1'b0; mask = '0; dwell = '0;
    test_reset();
    test_ascending();
    test_descending_sparse();
    test_single_step();
    test_mask_edges();
    test_single_channel();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
